carry_pipe_adder: RTL and testbench

- Pipelined WIDTH-bit adder for the assembly-line datapath.
- Splits operands into STAGES equal chunks. Each chunk is summed with per-bit sum/carry cells in its own pipeline stage, and a registered carry passes from stage to stage.
- Sits directly upstream of result consumers and accepts operands through a valid/ready handshake.
- Sustains one addition per cycle with a fixed latency of STAGES cycles.

---
 rtl/carry_pipe_adder.sv | 93 +++++++++
 tb/tb_carry_pipe_adder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/carry_pipe_adder.sv
// Pipelined WIDTH-bit adder: one CW-bit chunk per stage with a registered carry between stages.
// A valid/ready handshake fronts the pipe; the whole pipe advances together whenever the output can move.
module carry_pipe_adder #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CW = WIDTH / STAGES;
   localparam int unsigned SW = CW + 1;

   logic en;

   // The pipe moves only when the output register is empty or being drained.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      // b keeps only its unconsumed chunks; a carries finished sum chunks in its low bits.
      localparam int unsigned RW = WIDTH - k * CW;

      logic             v_r;
      logic             c_r;
      logic [WIDTH-1:0] a_r;
      logic [RW-1:0]    b_r;
      logic [SW-1:0]    st;
      logic [WIDTH-1:0] a_nx;

      assign st = SW'(a_r[k*CW +: CW]) + SW'(b_r[CW-1:0]) + SW'(c_r);

      always_comb begin
         a_nx                = a_r;
         a_nx[k*CW +: CW]    = st[CW-1:0];
      end

      if (k == 0) begin : g_in
         always_ff @(posedge clk) begin
            if (rst) begin
               v_r <= 1'b0;
               c_r <= 1'b0;
               a_r <= '0;
               b_r <= '0;
            end else if (en) begin
               v_r <= in_valid;
               c_r <= cin;
               a_r <= a;
               b_r <= b;
            end
         end
      end else begin : g_mid
         always_ff @(posedge clk) begin
            if (rst) begin
               v_r <= 1'b0;
               c_r <= 1'b0;
               a_r <= '0;
               b_r <= '0;
            end else if (en) begin
               v_r <= g_st[k-1].v_r;
               c_r <= g_st[k-1].st[CW];
               a_r <= g_st[k-1].a_nx;
               b_r <= g_st[k-1].b_r[WIDTH-(k-1)*CW-1 : CW];
            end
         end
      end
   end

   // Output data loads only behind a valid result so bubbles never disturb sum/cout.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
      end else if (en) begin
         out_valid <= g_st[STAGES-1].v_r;
         if (g_st[STAGES-1].v_r) begin
            sum  <= g_st[STAGES-1].a_nx;
            cout <= g_st[STAGES-1].st[CW];
         end
      end
   end

endmodule

// File: tb/tb_carry_pipe_adder.sv
// Self-checking bench for carry_pipe_adder: directed vector table, throughput, backpressure,
// mid-flight reset and a randomized run scored against a plain a+b+cin reference queue.
module tb_carry_pipe_adder;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned STAGES = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int checks   = 0;
   int failures = 0;
   int n_push   = 0;
   logic [WIDTH:0] exp_q [$];

   carry_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
      string      name;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference scoreboard: every accepted operand set predicts one in-order result.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_output", 32'(1), 32'(0));
            end else begin
               chk("sb_result", 32'({cout, sum}), 32'(exp_q.pop_front()));
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(9'(a) + 9'(b) + 9'(cin));
            n_push++;
         end
      end
   end

   initial begin
      vec_t vecs [7];
      logic [8:0] bp_exp [4];
      int lat;
      int got_n;
      int base;
      int cyc;
      int stale;
      logic [7:0] tp_sum [$];
      int         tp_cyc [$];

      vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ripple"};
      vecs[1] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, "cin_7f"};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "cin_ff"};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero"};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "msb_carry"};
      vecs[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, "alt_ripple"};
      vecs[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "chunk_cross"};

      repeat (2) tick();
      rst = 1'b0;
      chk("reset_out_valid", 32'(out_valid), 32'(0));
      chk("reset_sum", 32'(sum), 32'(0));
      chk("reset_cout", 32'(cout), 32'(0));
      chk("reset_in_ready", 32'(in_ready), 32'(1));

      // Directed vectors, one at a time, with latency measured from the accept edge.
      for (int i = 0; i < 7; i++) begin
         a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
         in_valid = 1'b1; out_ready = 1'b1;
         tick();
         in_valid = 1'b0;
         lat = 0;
         while (!out_valid && lat < 20) begin
            tick();
            lat++;
         end
         chk({vecs[i].name, "_latency"}, 32'(lat), 32'(STAGES));
         chk({vecs[i].name, "_sum"}, 32'(sum), 32'(vecs[i].sum));
         chk({vecs[i].name, "_cout"}, 32'(cout), 32'(vecs[i].cout));
         tick();
      end

      // Back-to-back pairs (i, 2i) must come out on consecutive cycles, in order.
      for (int c = 0; c < 20; c++) begin
         if (c < 6) begin
            a = 8'(c + 1); b = 8'(2 * (c + 1)); cin = 1'b0; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (out_valid) begin
            tp_sum.push_back(sum);
            tp_cyc.push_back(c);
         end
      end
      chk("tp_count", 32'(tp_sum.size()), 32'(6));
      for (int i = 0; i < tp_sum.size() && i < 6; i++) begin
         chk("tp_sum", 32'(tp_sum[i]), 32'(3 * (i + 1)));
         chk("tp_consecutive", 32'(tp_cyc[i]), 32'(tp_cyc[0] + i));
      end

      // Fill with four ops while the consumer is blocked, then poke inputs during the stall.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a = 8'(16 + i * 5); b = 8'(i * 67); cin = 1'(i);
         bp_exp[i] = 9'(a) + 9'(b) + 9'(cin);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("bp_stall_in_ready", 32'(in_ready), 32'(0));
      for (int s = 0; s < 5; s++) begin
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); in_valid = 1'b1;
         tick();
         chk("bp_frozen_in_ready", 32'(in_ready), 32'(0));
         chk("bp_frozen_valid", 32'(out_valid), 32'(1));
         chk("bp_frozen_result", 32'({cout, sum}), 32'(bp_exp[0]));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 32'(in_ready), 32'(1));
      got_n = 0;
      for (int c = 0; c < 12 && got_n < 4; c++) begin
         if (out_valid) begin
            chk("bp_drain_result", 32'({cout, sum}), 32'(bp_exp[got_n]));
            chk("bp_drain_cycle", 32'(c), 32'(got_n));
            got_n++;
         end
         tick();
      end
      chk("bp_drain_count", 32'(got_n), 32'(4));
      repeat (3) tick();

      // Reset lands while three ops are in flight; none of them may surface.
      out_ready = 1'b1;
      a = 8'h21; b = 8'h13; cin = 1'b0; in_valid = 1'b1;
      tick();
      a = 8'h42; b = 8'h05; cin = 1'b1;
      tick();
      a = 8'h30; b = 8'h30; cin = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_mid_out_valid", 32'(out_valid), 32'(0));
      chk("rst_mid_sum", 32'(sum), 32'(0));
      chk("rst_mid_cout", 32'(cout), 32'(0));
      stale = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (out_valid) stale++;
      end
      chk("rst_mid_no_stale", 32'(stale), 32'(0));

      // Random operands with random valid and ready duty.
      base = n_push;
      cyc = 0;
      while (n_push - base < 1000 && cyc < 20000) begin
         in_valid  = ($urandom_range(0, 4) != 0);
         a         = 8'($urandom);
         b         = 8'($urandom);
         cin       = 1'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("rand_sent", 32'(n_push - base), 32'(1000));
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 200) begin
         tick();
         cyc++;
      end
      chk("rand_drain_empty", 32'(exp_q.size()), 32'(0));
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
